// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the fetch/LSB requesters, the arbiter and
// the byte-serial memory controller.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_data;
  logic        ls_req;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [3:0]  ls_op;
  logic        ls_ready;
  logic [31:0] ls_rdata;
  logic        mc_lsb_need;
  logic [31:0] mc_addr;
  logic [31:0] mc_data;
  logic [3:0]  mc_op;
  logic        mc_icache_need;
  logic [31:0] mc_ins_addr;
  logic        mc_lsb_val_ready;
  logic [31:0] mc_lsb_val;
  logic        mc_ins_ready;
  logic [31:0] mc_ins;

  modport slave (
    input  if_req, if_addr, ls_req, ls_addr, ls_wdata, ls_op,
           mc_lsb_val_ready, mc_lsb_val, mc_ins_ready, mc_ins,
    output if_ready, if_data, ls_ready, ls_rdata,
           mc_lsb_need, mc_addr, mc_data, mc_op, mc_icache_need, mc_ins_addr
  );

  modport master (
    output if_req, if_addr, ls_req, ls_addr, ls_wdata, ls_op,
           mc_lsb_val_ready, mc_lsb_val, mc_ins_ready, mc_ins,
    input  if_ready, if_data, ls_ready, ls_rdata,
           mc_lsb_need, mc_addr, mc_data, mc_op, mc_icache_need, mc_ins_addr
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter between fetch and LSB in front of the memory
// controller, with starvation guard, flush discard and IO-store hold.
module mem_arbiter #(
  parameter int          STARVE_LIMIT = 4,
  parameter logic [1:0]  IO_ADDR_HI   = 2'b11
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  input  logic          flush_in,
  input  logic          io_buffer_full,
  mem_arbiter_if.slave  bus
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_LS, WAIT_IF, DONE} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  op;
  } ls_req_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   starve_cnt;
  logic            discard;
  logic            done_ls;   // transaction in flight belongs to the LSB
  logic            done_st;   // ... and is a store
  ls_req_t         mc_req;
  logic [31:0]     ins_addr_q, if_data_q, ls_rdata_q;
  logic            ls_elig, starved, gnt_ls, gnt_if, pulse_ok;

  // An IO store facing a full IO buffer is invisible to arbitration.
  assign ls_elig = bus.ls_req &&
                   !(bus.ls_op[3] && bus.ls_addr[17:16] == IO_ADDR_HI && io_buffer_full);
  assign starved = bus.if_req && (starve_cnt == CW'(STARVE_LIMIT));

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)     state <= IDLE;
    else if (rdy_in) state <= state_nxt;
  end

  always_comb begin
    state_nxt          = state;
    gnt_ls             = 1'b0;
    gnt_if             = 1'b0;
    bus.mc_lsb_need    = 1'b0;
    bus.mc_icache_need = 1'b0;
    pulse_ok           = 1'b0;
    unique case (state)
      IDLE: if (!flush_in) begin
        if (ls_elig && !starved) begin
          gnt_ls    = 1'b1;
          state_nxt = WAIT_LS;
        end else if (bus.if_req) begin
          gnt_if    = 1'b1;
          state_nxt = WAIT_IF;
        end
      end
      WAIT_LS: begin
        bus.mc_lsb_need = 1'b1;
        if (bus.mc_lsb_val_ready) state_nxt = DONE;
      end
      WAIT_IF: begin
        bus.mc_icache_need = 1'b1;
        if (bus.mc_ins_ready) state_nxt = DONE;
      end
      DONE: begin
        // A flush landing in DONE still kills a fetch/load result; a store is already committed.
        pulse_ok  = !discard && (done_st || !flush_in);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.ls_ready    = pulse_ok && done_ls;
  assign bus.if_ready    = pulse_ok && !done_ls;
  assign bus.mc_addr     = mc_req.addr;
  assign bus.mc_data     = mc_req.data;
  assign bus.mc_op       = mc_req.op;
  assign bus.mc_ins_addr = ins_addr_q;
  assign bus.if_data     = if_data_q;
  assign bus.ls_rdata    = ls_rdata_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mc_req     <= '0;
      ins_addr_q <= '0;
      if_data_q  <= '0;
      ls_rdata_q <= '0;
      done_ls    <= 1'b0;
      done_st    <= 1'b0;
      discard    <= 1'b0;
      starve_cnt <= '0;
    end else if (rdy_in) begin
      if (gnt_ls) begin
        mc_req  <= '{addr: bus.ls_addr, data: bus.ls_wdata, op: bus.ls_op};
        done_ls <= 1'b1;
        done_st <= bus.ls_op[3];
      end
      if (gnt_if) begin
        ins_addr_q <= bus.if_addr;
        done_ls    <= 1'b0;
        done_st    <= 1'b0;
      end
      if (state == WAIT_LS && bus.mc_lsb_val_ready) ls_rdata_q <= bus.mc_lsb_val;
      if (state == WAIT_IF && bus.mc_ins_ready)     if_data_q  <= bus.mc_ins;

      if (gnt_if || (state == IDLE && !bus.if_req))
        starve_cnt <= '0;
      else if (gnt_ls && starve_cnt != CW'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + 1'b1;

      if (state == DONE)
        discard <= 1'b0;
      else if (flush_in && ((state == WAIT_LS && !done_st) || state == WAIT_IF))
        discard <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized + directed bench for mem_arbiter: requester/memory-controller
// environment, queue scoreboard and grant-order log checked by a monitor.
module tb_mem_arbiter;
  logic clk_in = 1'b0, rst_in = 1'b0, rdy_in = 1'b1, flush_in = 1'b0, io_buffer_full = 1'b0;
  mem_arbiter_if bus();

  mem_arbiter #(.STARVE_LIMIT(4), .IO_ADDR_HI(2'b11)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .io_buffer_full(io_buffer_full), .bus(bus)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0, errors = 0;
  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endfunction

  // Memory-controller content: what a fetch / load-store at a given payload returns.
  function automatic logic [31:0] fetch_word(logic [31:0] a);
    return (a == 32'h0000_1000) ? 32'h0051_0113 : ((a * 32'h9E37_79B1) ^ 32'h1357_9BDF);
  endfunction
  function automatic logic [31:0] ls_word(logic [31:0] a, logic [3:0] op, logic [31:0] d);
    return ((a ^ {op, 28'h0}) * 32'h85EB_CA6B) ^ d;
  endfunction

  // scoreboard and grant log
  logic [31:0] if_q[$], ls_q[$];
  logic [7:0]  glog[$];
  int n_ifr = 0, n_lsr = 0, cyc = 0, f_rise_cyc = 0, lsr_cyc = 0;

  // environment knobs
  bit          rnd = 0, ov_ls = 0, if_fix = 0, flush_req = 0, io_knob = 0, pause_knob = 0;
  int          if_left = 0, ls_left = 0, lat = 1;
  logic [31:0] if_fix_addr = 0, ov_addr = 0, ov_wdata = 0;
  logic [3:0]  ov_op = 0;

  // Environment: requesters + memory controller, acting just after each edge.
  initial begin : env
    bit          if_out, ls_out, ls_out_st, s_ifr, s_lsr, s_rdy, s_ineed, s_lneed;
    int          mi_wait, ml_wait;
    logic [31:0] s_iaddr, s_laddr, s_ldata, a, d;
    logic [3:0]  s_lop, op;
    if_out = 0; ls_out = 0; ls_out_st = 0; mi_wait = 0; ml_wait = 0;
    bus.if_req = 0; bus.if_addr = 0; bus.ls_req = 0; bus.ls_addr = 0; bus.ls_wdata = 0;
    bus.ls_op = 0; bus.mc_lsb_val_ready = 0; bus.mc_lsb_val = 0; bus.mc_ins_ready = 0; bus.mc_ins = 0;
    forever begin
      @(negedge clk_in);
      s_ifr = bus.if_ready; s_lsr = bus.ls_ready; s_rdy = rdy_in;
      s_ineed = bus.mc_icache_need; s_lneed = bus.mc_lsb_need; s_iaddr = bus.mc_ins_addr;
      s_laddr = bus.mc_addr; s_lop = bus.mc_op; s_ldata = bus.mc_data;
      @(posedge clk_in); #1;
      if (!rst_in) begin
        if_out = 0; ls_out = 0; mi_wait = 0; ml_wait = 0;
        bus.if_req = 0; bus.ls_req = 0; bus.mc_ins_ready = 0; bus.mc_lsb_val_ready = 0;
        flush_in = 0; rdy_in = 1;
        if_q.delete(); ls_q.delete();
      end else begin
        if (s_rdy && s_ifr) begin if_out = 0; bus.if_req = 0; end
        if (s_rdy && s_lsr) begin ls_out = 0; bus.ls_req = 0; end
        if (bus.mc_ins_ready) begin
          if (s_rdy) bus.mc_ins_ready = 0;
        end else if (s_ineed && s_rdy) begin
          if (rnd ? ($urandom_range(0, 2) == 0) : (mi_wait >= lat)) begin
            bus.mc_ins_ready = 1; bus.mc_ins = fetch_word(s_iaddr); mi_wait = 0;
          end else mi_wait++;
        end
        if (bus.mc_lsb_val_ready) begin
          if (s_rdy) bus.mc_lsb_val_ready = 0;
        end else if (s_lneed && s_rdy) begin
          if (rnd ? ($urandom_range(0, 2) == 0) : (ml_wait >= lat)) begin
            bus.mc_lsb_val_ready = 1; bus.mc_lsb_val = ls_word(s_laddr, s_lop, s_ldata); ml_wait = 0;
          end else ml_wait++;
        end
        rdy_in = rnd ? ($urandom_range(0, 9) != 0) : !pause_knob;
        io_buffer_full = rnd ? (($urandom_range(0, 5) == 0) ? ~io_buffer_full : io_buffer_full) : io_knob;
        flush_in = rdy_in && (flush_req || (rnd && $urandom_range(0, 24) == 0));
        flush_req = 0;
        // A flush kills pending fetches and loads; the requester gives them up.
        if (flush_in && if_out) begin if_out = 0; bus.if_req = 0; if_q.delete(if_q.size() - 1); end
        if (flush_in && ls_out && !ls_out_st) begin ls_out = 0; bus.ls_req = 0; ls_q.delete(ls_q.size() - 1); end
        if (!if_out && if_left != 0 && (!rnd || $urandom_range(0, 3) == 0)) begin
          bus.if_addr = if_fix ? if_fix_addr : ($urandom & 32'hFFFF_FFFC);
          bus.if_req = 1; if_out = 1;
          if_q.push_back(fetch_word(bus.if_addr));
          if (if_left > 0) if_left--;
        end
        if (!ls_out && ls_left != 0 && (!rnd || $urandom_range(0, 3) == 0)) begin
          if (ov_ls) begin a = ov_addr; op = ov_op; d = ov_wdata; end
          else begin
            a = $urandom;
            if ($urandom_range(0, 2) == 0) a[17:16] = 2'b11;
            op = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))};
            d = $urandom;
          end
          bus.ls_addr = a; bus.ls_op = op; bus.ls_wdata = d; bus.ls_req = 1;
          ls_out = 1; ls_out_st = op[3];
          ls_q.push_back(ls_word(a, op, d));
          if (ls_left > 0) ls_left--;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted ready pulse, logs grant order.
  bit p_rdy = 0, p_ins_rdy = 0, p_lsb_rdy = 0, p_ineed = 0, p_lneed = 0;
  always @(negedge clk_in) begin
    cyc++;
    if (rst_in) begin
      chk("need_exclusive", {bus.mc_lsb_need, bus.mc_icache_need}, (bus.mc_lsb_need ? 2'b10 : {1'b0, bus.mc_icache_need}));
      if (bus.if_ready && rdy_in) begin
        n_ifr++;
        if (if_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL if_unexpected: if_ready with data %0h, expected no pulse", bus.if_data);
        end else chk("if_data", bus.if_data, if_q.pop_front());
        chk("if_need_low_at_ready", bus.mc_icache_need, 1'b0);
        if (p_rdy) chk("if_latency", p_ins_rdy, 1'b1);
      end
      if (bus.ls_ready && rdy_in) begin
        n_lsr++; lsr_cyc = cyc;
        if (ls_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL ls_unexpected: ls_ready with data %0h, expected no pulse", bus.ls_rdata);
        end else chk("ls_rdata", bus.ls_rdata, ls_q.pop_front());
        if (p_rdy) chk("ls_latency", p_lsb_rdy, 1'b1);
      end
      if (bus.mc_lsb_need && !p_lneed) glog.push_back(8'h4C);
      if (bus.mc_icache_need && !p_ineed) begin glog.push_back(8'h46); f_rise_cyc = cyc; end
    end
    p_rdy = rdy_in; p_ins_rdy = bus.mc_ins_ready; p_lsb_rdy = bus.mc_lsb_val_ready;
    p_ineed = bus.mc_icache_need; p_lneed = bus.mc_lsb_need;
  end

  task automatic tick(); @(negedge clk_in); #1; endtask

  task automatic wait_ready(input int wi, input int wl, input int budget, input string nm);
    int t = 0;
    while ((n_ifr < wi || n_lsr < wl) && t < budget) begin tick(); t++; end
    chk({nm, "_if_count"}, n_ifr, wi);
    chk({nm, "_ls_count"}, n_lsr, wl);
  endtask

  task automatic wait_need(input bit ls, input string nm);
    int t = 0;
    while (!(ls ? bus.mc_lsb_need : bus.mc_icache_need) && t < 40) begin tick(); t++; end
    chk(nm, ls ? bus.mc_lsb_need : bus.mc_icache_need, 1'b1);
  endtask

  task automatic check_zero(input string nm);
    logic [167:0] o;
    o = {bus.if_ready, bus.if_data, bus.ls_ready, bus.ls_rdata, bus.mc_lsb_need, bus.mc_addr,
         bus.mc_data, bus.mc_op, bus.mc_icache_need, bus.mc_ins_addr};
    checks++;
    if (o !== '0) begin errors++; $display("FAIL %s: outputs %0h, expected 0", nm, o); end
  endtask

  initial begin : main
    int bi, bl, cnt, nl;
    logic [7:0] e;
    repeat (3) tick();
    check_zero("reset_state");
    rst_in = 1; tick();

    // single fetch
    bi = n_ifr; glog.delete(); if_fix = 1; if_fix_addr = 32'h0000_1000; lat = 3; if_left = 1;
    wait_ready(bi + 1, n_lsr, 40, "single_fetch");
    chk("single_fetch_data", bus.if_data, 32'h0051_0113);
    chk("single_fetch_grants", glog.size(), 1);
    repeat (4) tick();

    // simultaneous fetch and load: LSB first, fetch granted in the IDLE after ls_ready
    bi = n_ifr; bl = n_lsr; glog.delete(); lat = 1;
    ov_ls = 1; ov_addr = 32'h200; ov_op = 4'b0010; ov_wdata = 0; if_fix_addr = 32'h2000;
    if_left = 1; ls_left = 1;
    wait_ready(bi + 1, bl + 1, 60, "simul");
    chk("simul_order_len", glog.size(), 2);
    if (glog.size() == 2) begin chk("simul_first", glog[0], 8'h4C); chk("simul_second", glog[1], 8'h46); end
    chk("simul_fetch_gap", f_rise_cyc - lsr_cyc, 2);
    repeat (4) tick();

    // starvation: both requesters busy back-to-back
    glog.delete(); ov_addr = 32'h400; if_fix_addr = 32'h3000; if_left = -1; ls_left = -1;
    begin int t = 0; while (glog.size() < 12 && t < 400) begin tick(); t++; end end
    if_left = 0; ls_left = 0;
    chk("starve_len", glog.size() >= 12, 1'b1);
    cnt = 0;
    for (int i = 0; i < 12 && i < glog.size(); i++) begin
      if (cnt < 4) begin e = 8'h4C; cnt++; end else begin e = 8'h46; cnt = 0; end
      chk($sformatf("starve_seq_%0d", i), glog[i], e);
    end
    repeat (30) tick();
    chk("starve_drain", if_q.size() + ls_q.size(), 0);

    // IO store held while the IO buffer is full; fetch bypasses it
    bi = n_ifr; bl = n_lsr; glog.delete(); io_knob = 1;
    ov_addr = 32'h0003_0000; ov_op = 4'b1010; ov_wdata = 32'hDEAD_BEEF; if_fix_addr = 32'h3000;
    ls_left = 1; if_left = 1;
    repeat (12) tick();
    chk("io_fetch_done", n_ifr, bi + 1);
    chk("io_store_held", n_lsr, bl);
    nl = 0; foreach (glog[i]) if (glog[i] == 8'h4C) nl++;
    chk("io_no_lsb_need", nl, 0);
    io_knob = 0;
    wait_ready(bi + 1, bl + 1, 30, "io_release");
    chk("io_grant_order", glog.size() == 2 && glog[1] == 8'h4C, 1'b1);
    repeat (4) tick();

    // flush during a load: result discarded
    bl = n_lsr; lat = 8; ov_addr = 32'h300; ov_op = 4'b0010; ls_left = 1;
    wait_need(1, "flush_load_need");
    repeat (2) tick(); flush_req = 1;
    repeat (25) tick();
    chk("flush_load_no_ready", n_lsr, bl);
    chk("flush_load_idle", {bus.mc_lsb_need, bus.mc_icache_need}, 2'b00);
    chk("flush_load_sb", ls_q.size(), 0);

    // flush during a store: still acknowledged
    ov_op = 4'b1010; ov_wdata = 32'h1234_5678; ls_left = 1;
    wait_need(1, "flush_store_need");
    repeat (2) tick(); flush_req = 1;
    wait_ready(n_ifr, bl + 1, 30, "flush_store");
    chk("flush_store_sb", ls_q.size(), 0);

    // pause mid-fetch, then async reset mid-load
    bi = n_ifr; lat = 10; if_fix_addr = 32'h4000; if_left = 1;
    wait_need(0, "pause_need");
    pause_knob = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("pause_need_held", bus.mc_icache_need, 1'b1);
      chk("pause_addr_held", bus.mc_ins_addr, 32'h4000);
      chk("pause_no_ready", bus.if_ready, 1'b0);
    end
    pause_knob = 0;
    wait_ready(bi + 1, n_lsr, 40, "pause_resume");
    ov_addr = 32'h500; ov_op = 4'b0010; ls_left = 1;
    wait_need(1, "reset_need");
    tick(); #1 rst_in = 0; #1;
    check_zero("async_reset");
    repeat (2) tick(); rst_in = 1; tick();
    bi = n_ifr; lat = 1; if_fix_addr = 32'h1000; if_left = 1;
    wait_ready(bi + 1, n_lsr, 30, "post_reset_fetch");
    repeat (4) tick();

    // randomized traffic with pauses, flushes and IO-buffer toggling
    if_fix = 0; ov_ls = 0; rnd = 1; if_left = -1; ls_left = -1;
    repeat (3000) tick();
    rnd = 0; if_left = 0; ls_left = 0; lat = 2; io_knob = 0;
    repeat (60) tick();
    chk("random_if_drain", if_q.size(), 0);
    chk("random_ls_drain", ls_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
